// File: rtl/main_run_controller.sv
// Run sequencer for the HLS `main` accelerator: serialises host memory
// accesses and compute runs, with cycle counting and a timeout watchdog.
module main_run_controller #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_req,
  output logic             run_done,
  output logic [1:0]       run_status,
  output logic [CNT_W-1:0] cycle_count,
  output logic             busy,
  input  logic             mem_req,
  input  logic             mem_we,
  input  logic [8:0]       mem_addr,
  input  logic [63:0]      mem_wdata,
  input  logic [6:0]       mem_size,
  output logic [63:0]      mem_rdata,
  output logic             mem_ack,
  output logic             start_port,
  input  logic             done_port,
  output logic             acc_reset,
  output logic [1:0]       S_oe_ram,
  output logic [1:0]       S_we_ram,
  output logic [17:0]      S_addr_ram,
  output logic [127:0]     S_Wdata_ram,
  output logic [13:0]      S_data_ram_size,
  input  logic [127:0]     Sout_Rdata_ram,
  input  logic [1:0]       Sout_DataRdy
);

  typedef enum logic [2:0] {
    IDLE, MEM, MACK, START, RUN, ABORT, DONE
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_t state, state_d;
  logic   abort_q;

  // Channel 1 of the slave port is never used.
  logic unused_in;
  assign unused_in = &{1'b0, Sout_Rdata_ram[127:64], Sout_DataRdy[1]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      abort_q <= 1'b0;
    end else begin
      state   <= state_d;
      abort_q <= (state == ABORT);
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (mem_req)      state_d = MEM;
        else if (run_req) state_d = START;
      end
      MEM:   if (Sout_DataRdy[0]) state_d = MACK;
      MACK:  if (!mem_req) state_d = IDLE;
      START: state_d = done_port ? DONE : RUN;
      RUN: begin
        if (done_port)              state_d = DONE;
        else if (cycle_count == TMO) state_d = ABORT;
      end
      ABORT: if (abort_q) state_d = DONE;
      DONE:  if (!run_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      start_port      <= 1'b0;
      run_done        <= 1'b0;
      mem_ack         <= 1'b0;
      busy            <= 1'b0;
      acc_reset       <= 1'b0;
      run_status      <= 2'b00;
      cycle_count     <= '0;
      mem_rdata       <= '0;
      S_oe_ram        <= '0;
      S_we_ram        <= '0;
      S_addr_ram      <= '0;
      S_Wdata_ram     <= '0;
      S_data_ram_size <= '0;
    end else begin
      start_port <= (state_d == START);
      run_done   <= (state_d == DONE);
      mem_ack    <= (state_d == MACK);
      busy       <= (state_d != IDLE);
      acc_reset  <= (state_d != ABORT);

      if (state == IDLE && state_d == START)
        cycle_count <= CNT_W'(1);
      else if (state_d == RUN)
        cycle_count <= cycle_count + CNT_W'(1);

      if (state_d == DONE && state != DONE)
        run_status <= (state == ABORT) ? 2'b10 : 2'b01;

      if (state == IDLE && state_d == MEM) begin
        S_oe_ram        <= {1'b0, ~mem_we};
        S_we_ram        <= {1'b0, mem_we};
        S_addr_ram      <= {9'd0, mem_addr};
        S_Wdata_ram     <= {64'd0, mem_wdata};
        S_data_ram_size <= {7'd0, mem_size};
      end else if (state_d != MEM) begin
        S_oe_ram        <= '0;
        S_we_ram        <= '0;
        S_addr_ram      <= '0;
        S_Wdata_ram     <= '0;
        S_data_ram_size <= '0;
      end

      if (state == MEM && Sout_DataRdy[0] && !S_we_ram[0])
        mem_rdata <= Sout_Rdata_ram[63:0];
    end
  end

endmodule

// File: tb/tb_main_run_controller.sv
// Self-checking bench for main_run_controller with a behavioural
// accelerator/slave model and randomized runs and accesses.
module tb_main_run_controller;
  localparam int T = 20;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         run_req = 1'b0;
  logic         mem_req = 1'b0;
  logic         mem_we = 1'b0;
  logic [8:0]   mem_addr = '0;
  logic [63:0]  mem_wdata = '0;
  logic [6:0]   mem_size = '0;
  logic         done_port = 1'b0;
  logic [127:0] Sout_Rdata_ram = '0;
  logic [1:0]   Sout_DataRdy = '0;

  logic         run_done, busy, mem_ack, start_port, acc_reset;
  logic [1:0]   run_status, S_oe_ram, S_we_ram;
  logic [31:0]  cycle_count;
  logic [63:0]  mem_rdata;
  logic [17:0]  S_addr_ram;
  logic [127:0] S_Wdata_ram;
  logic [13:0]  S_data_ram_size;

  int errors = 0;
  int checks = 0;
  logic [63:0] model_mem [512];
  logic [63:0] exp_rdata = '0;

  main_run_controller #(.CNT_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset),
    .run_req(run_req), .run_done(run_done),
    .run_status(run_status), .cycle_count(cycle_count),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .start_port(start_port),
    .done_port(done_port), .acc_reset(acc_reset),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram),
    .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
    .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram),
    .Sout_DataRdy(Sout_DataRdy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({start_port, run_done, mem_ack, busy, acc_reset} !== 5'b0 ||
        run_status !== 2'b00 || cycle_count !== 32'd0 ||
        mem_rdata !== 64'd0 || S_oe_ram !== 2'b0 || S_we_ram !== 2'b0 ||
        S_addr_ram !== 18'd0 || S_Wdata_ram !== 128'd0 ||
        S_data_ram_size !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b st=%b cnt=%0d rd=%h required all zero",
               {start_port, run_done, mem_ack, busy, acc_reset},
               run_status, cycle_count, mem_rdata);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (acc_reset !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: acc_reset=%b busy=%b required 1 0",
               acc_reset, busy);
    end
    exp_rdata = '0;
  endtask

  // One slave access; the slave model answers after lat extra cycles.
  task automatic do_mem(input logic we, input logic [8:0] addr,
                        input logic [63:0] data, input logic [6:0] size,
                        input int lat, input logic raise_run);
    logic [63:0] rd;
    mem_req = 1'b1; mem_we = we; mem_addr = addr;
    mem_wdata = data; mem_size = size;
    tick();
    mem_we = ~we; mem_addr = ~addr; mem_wdata = ~data; mem_size = ~size;
    if (raise_run) run_req = 1'b1;
    for (int i = 0; i <= lat; i++) begin
      checks++;
      if (S_oe_ram !== {1'b0, ~we} || S_we_ram !== {1'b0, we} ||
          S_addr_ram !== {9'd0, addr} ||
          S_data_ram_size !== {7'd0, size} ||
          (we && S_Wdata_ram !== {64'd0, data})) begin
        errors++;
        $display("FAIL mem_drive: oe=%b we=%b addr=%h size=%h required oe=%b we=%b addr=%h size=%h",
                 S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size,
                 {1'b0, ~we}, {1'b0, we}, {9'd0, addr}, {7'd0, size});
      end
      checks++;
      if (mem_ack !== 1'b0 || start_port !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL mem_wait: ack=%b start=%b busy=%b required 0 0 1",
                 mem_ack, start_port, busy);
      end
      if (i == lat) begin
        rd = we ? {$urandom, $urandom} : model_mem[addr];
        Sout_DataRdy = 2'b01;
        Sout_Rdata_ram = {$urandom, $urandom, rd};
      end
      tick();
    end
    Sout_DataRdy = 2'b00;
    Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
    if (we) model_mem[addr] = data;
    else exp_rdata = model_mem[addr];
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (mem_ack !== 1'b1 || mem_rdata !== exp_rdata ||
          start_port !== 1'b0) begin
        errors++;
        $display("FAIL mem_ack: ack=%b rdata=%h start=%b required 1 %h 0",
                 mem_ack, mem_rdata, start_port, exp_rdata);
      end
      if (j == 0) begin
        checks++;
        if (S_oe_ram !== 2'b0 || S_we_ram !== 2'b0 || S_addr_ram !== 18'd0 ||
            S_Wdata_ram !== 128'd0 || S_data_ram_size !== 14'd0) begin
          errors++;
          $display("FAIL mem_release: oe=%b we=%b addr=%h required all 0",
                   S_oe_ram, S_we_ram, S_addr_ram);
        end
      end
      tick();
    end
    mem_req = 1'b0;
    tick();
    checks++;
    if (mem_ack !== 1'b0 || busy !== 1'b0 || start_port !== 1'b0) begin
      errors++;
      $display("FAIL mem_end: ack=%b busy=%b start=%b required 0 0 0",
               mem_ack, busy, start_port);
    end
  endtask

  // Run whose done_port pulse comes n cycles after the start cycle.
  task automatic do_run(input int n);
    int tdone, starts, lows, exp_t, exp_cnt, exp_lows;
    logic [1:0] exp_st;
    bit completed;
    completed = (n < T);
    exp_t    = completed ? n + 1 : T + 2;
    exp_cnt  = completed ? n + 1 : T;
    exp_lows = completed ? 0 : 2;
    exp_st   = completed ? 2'b01 : 2'b10;
    tdone = -1; starts = 0; lows = 0;
    run_req = 1'b1;
    for (int t = 0; t < 80; t++) begin
      tick();
      if (start_port === 1'b1) starts++;
      if (acc_reset === 1'b0) lows++;
      if (t < T && t <= n) begin
        checks++;
        if (cycle_count !== 32'(t + 1)) begin
          errors++;
          $display("FAIL run_count_t%0d: cnt=%0d required %0d",
                   t, cycle_count, t + 1);
        end
      end
      if (run_done === 1'b1) begin
        tdone = t;
        break;
      end
      done_port = (t == n);
    end
    done_port = 1'b0;
    checks++;
    if (tdone != exp_t) begin
      errors++;
      $display("FAIL run_latency n=%0d: done at %0d required %0d",
               n, tdone, exp_t);
    end
    checks++;
    if (cycle_count !== 32'(exp_cnt) || run_status !== exp_st) begin
      errors++;
      $display("FAIL run_result n=%0d: cnt=%0d st=%b required %0d %b",
               n, cycle_count, run_status, exp_cnt, exp_st);
    end
    checks++;
    if (starts != 1 || lows != exp_lows) begin
      errors++;
      $display("FAIL run_pulses n=%0d: starts=%0d acc_low=%0d required 1 %0d",
               n, starts, lows, exp_lows);
    end
    run_req = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || run_done !== 1'b0 ||
        cycle_count !== 32'(exp_cnt) || run_status !== exp_st) begin
      errors++;
      $display("FAIL run_release n=%0d: busy=%b done=%b cnt=%0d st=%b",
               n, busy, run_done, cycle_count, run_status);
    end
  endtask

  task automatic test_write_read();
    do_mem(1'b1, 9'd3, 64'h5A, 7'd8, 1, 1'b0);
    do_mem(1'b0, 9'd3, 64'h0, 7'd8, 2, 1'b0);
  endtask

  task automatic test_runs();
    do_run(10);
    do_run(0);
    do_run(T - 1);
    do_run(T + 5);
  endtask

  task automatic test_arbitration();
    run_req = 1'b1;
    do_mem(1'b1, 9'd7, 64'hDEAD_BEEF_0123_4567, 7'd64, 0, 1'b0);
    do_run(3);
    do_mem(1'b0, 9'd7, 64'h0, 7'd64, 1, 1'b1);
    do_run(2);
  endtask

  task automatic test_ignored();
    Sout_DataRdy = 2'b11;
    done_port = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || mem_ack !== 1'b0 || run_done !== 1'b0 ||
        start_port !== 1'b0 || mem_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL ignored_idle: busy=%b ack=%b done=%b start=%b",
               busy, mem_ack, run_done, start_port);
    end
    Sout_DataRdy = 2'b00;
    done_port = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    run_req = 1'b1;
    for (int t = 0; t <= 5; t++) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || cycle_count !== 32'd0 || run_status !== 2'b00 ||
        acc_reset !== 1'b0 || run_done !== 1'b0 || start_port !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b cnt=%0d st=%b acc=%b done=%b",
               busy, cycle_count, run_status, acc_reset, run_done);
    end
    exp_rdata = '0;
    reset = 1'b1;
    run_req = 1'b0;
    tick();
    checks++;
    if (acc_reset !== 1'b1 || busy !== 1'b0 || run_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: acc=%b busy=%b done=%b required 1 0 0",
               acc_reset, busy, run_done);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 0)
        do_mem(1'($urandom_range(0, 1)), 9'($urandom_range(0, 7)),
               {$urandom, $urandom}, 7'($urandom_range(1, 64)),
               $urandom_range(0, 3), 1'b0);
      else
        do_run($urandom_range(0, T + 4));
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) model_mem[i] = {$urandom, $urandom};
    test_reset();
    test_write_read();
    test_runs();
    test_arbitration();
    test_ignored();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
